key_rotary_cond: RTL and testbench

//  Input conditioner between board buttons/rotary switch and counter32b-class blocks.

---
 rtl/key_rotary_cond_pkg.sv | 19 +
 rtl/key_rotary_cond_debounce.sv | 143 ++++++++++++++
 rtl/key_rotary_cond.sv | 110 +++++++++++
 tb/tb_key_rotary_cond.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_rotary_cond_pkg.sv
// Shared definitions for the key/rotary input conditioner.
//   key_state_e : per-key debounce FSM states (arm / idle / held)
//   SyncStages  : flops in each input synchroniser chain
//   max_u       : helper for sizing counters from several parameters
package key_rotary_cond_pkg;

    typedef enum logic [1:0] {
        StArm  = 2'd0,
        StIdle = 2'd1,
        StHeld = 2'd2
    } key_state_e;

    localparam int unsigned SyncStages = 2;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_rotary_cond_debounce.sv
// Single push-key conditioner: 2-FF synchroniser, debounce FSM and press pulse.
// Optional build macro: KEY_AUTOREPEAT_EN adds auto-repeat pulses while held.
// Ports:
//   clk_i    system clock
//   rst_ni   asynchronous active-low reset
//   key_ni   raw key, active-low, asynchronous
//   pulse_o  one-cycle pulse per debounced press (plus repeats when enabled)
//   held_o   debounced level, 1 = pressed
module key_rotary_cond_debounce
    import key_rotary_cond_pkg::*;
#(
    parameter int unsigned DB_CYCLES  = 2000,
    parameter int unsigned REPEAT_DLY = 5_000_000,
    parameter int unsigned REPEAT_PER = 1_000_000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_ni,
    output logic pulse_o,
    output logic held_o
);

    localparam int unsigned CntW = $clog2(DB_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DB_CYCLES - 1);
    localparam logic [CntW-1:0] CntTerm = CntW'(DB_CYCLES);

    logic [SyncStages-1:0] sync_q;
    logic                  synced;
    key_state_e            state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d, cnt_inc;
    logic                  pulse_q, pulse_d;
    logic                  press;

    assign synced  = sync_q[SyncStages-1];
    assign cnt_inc = (cnt_q == CntTerm) ? cnt_q : cnt_q + 1'b1;

    // Each state counts consecutive samples of the level that moves it on;
    // the opposite level restarts the count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press   = 1'b0;
        unique case (state_q)
            StArm: begin
                if (!synced) begin
                    cnt_d = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StIdle: begin
                if (synced) begin
                    cnt_d = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = StHeld;
                    cnt_d   = '0;
                    press   = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StHeld: begin
                if (!synced) begin
                    cnt_d = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = StArm;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = StArm;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef KEY_AUTOREPEAT_EN
    localparam int unsigned RepW = $clog2(max_u(REPEAT_DLY, REPEAT_PER) + 1);

    logic [RepW-1:0] rep_cnt_q, rep_cnt_d, rep_target;
    logic            rep_first_q, rep_first_d;
    logic            rep_pulse;

    assign rep_target = rep_first_q ? RepW'(REPEAT_DLY - 1) : RepW'(REPEAT_PER - 1);

    // Repeat timing only runs while staying in held; leaving held on the same
    // cycle a repeat would fall due suppresses that repeat.
    always_comb begin
        rep_cnt_d   = '0;
        rep_first_d = 1'b1;
        rep_pulse   = 1'b0;
        if (state_q == StHeld && state_d == StHeld) begin
            rep_first_d = rep_first_q;
            if (rep_cnt_q == rep_target) begin
                rep_pulse   = 1'b1;
                rep_cnt_d   = '0;
                rep_first_d = 1'b0;
            end else begin
                rep_cnt_d = rep_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b1;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_first_q <= rep_first_d;
        end
    end

    assign pulse_d = press | rep_pulse;
`else
    logic unused_rep_params;
    assign unused_rep_params = ^{REPEAT_DLY, REPEAT_PER};
    assign pulse_d = press;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= '1;
            state_q <= StArm;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SyncStages-2:0], key_ni};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;
    assign held_o  = (state_q == StHeld);

endmodule

// File: rtl/key_rotary_cond.sv
// Input conditioner for two active-low push keys and a 4-bit active-low rotary code.
// Optional build macro: KEY_AUTOREPEAT_EN (auto-repeat on held keys).
// Ports:
//   i_clk, i_rstn               clock, asynchronous active-low reset
//   i_key1_mode, i_key2_clear   raw keys, active-low, asynchronous
//   i_rotary[3:0]               raw rotary code, active-low, asynchronous
//   o_mode_pulse, o_clear_pulse one-cycle press pulses
//   o_key_held[1:0]             debounced levels {clear, mode}, 1 = pressed
//   o_rotary[3:0]               debounced true-polarity rotary value
//   o_rot_chg                   one-cycle pulse when o_rotary changes
module key_rotary_cond
    import key_rotary_cond_pkg::*;
#(
    parameter int unsigned DB_CYCLES  = 2000,
    parameter int unsigned REPEAT_DLY = 5_000_000,
    parameter int unsigned REPEAT_PER = 1_000_000
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_key1_mode,
    input  logic       i_key2_clear,
    input  logic [3:0] i_rotary,
    output logic       o_mode_pulse,
    output logic       o_clear_pulse,
    output logic [1:0] o_key_held,
    output logic [3:0] o_rotary,
    output logic       o_rot_chg
);

    localparam int unsigned RCntW = $clog2(DB_CYCLES + 1);
    localparam logic [RCntW-1:0] RCntLast = RCntW'(DB_CYCLES - 1);
    localparam logic [RCntW-1:0] RCntTerm = RCntW'(DB_CYCLES);

    logic mode_held, clear_held;

    key_rotary_cond_debounce #(
        .DB_CYCLES  (DB_CYCLES),
        .REPEAT_DLY (REPEAT_DLY),
        .REPEAT_PER (REPEAT_PER)
    ) u_key_mode (
        .clk_i   (i_clk),
        .rst_ni  (i_rstn),
        .key_ni  (i_key1_mode),
        .pulse_o (o_mode_pulse),
        .held_o  (mode_held)
    );

    key_rotary_cond_debounce #(
        .DB_CYCLES  (DB_CYCLES),
        .REPEAT_DLY (REPEAT_DLY),
        .REPEAT_PER (REPEAT_PER)
    ) u_key_clear (
        .clk_i   (i_clk),
        .rst_ni  (i_rstn),
        .key_ni  (i_key2_clear),
        .pulse_o (o_clear_pulse),
        .held_o  (clear_held)
    );

    assign o_key_held = {clear_held, mode_held};

    logic [SyncStages-1:0][3:0] rot_sync_q;
    logic [3:0]                 rot_synced;
    logic [3:0]                 cand_q, cand_d, cand_inv;
    logic [RCntW-1:0]           rcnt_q, rcnt_d;
    logic [3:0]                 rot_q, rot_d;
    logic                       chg_q, chg_d;

    assign rot_synced = rot_sync_q[SyncStages-1];
    assign cand_inv   = ~cand_q;

    // Loading a new candidate counts as its first stable sample, so a clean
    // change appears on o_rotary with the same latency as a key press.
    always_comb begin
        cand_d = cand_q;
        rcnt_d = rcnt_q;
        rot_d  = rot_q;
        chg_d  = 1'b0;
        if (rot_synced != cand_q) begin
            cand_d = rot_synced;
            rcnt_d = RCntW'(1);
        end else if (rcnt_q != RCntTerm) begin
            rcnt_d = rcnt_q + 1'b1;
            if (rcnt_q == RCntLast) begin
                rot_d = cand_inv;
                chg_d = (cand_inv != rot_q);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            rot_sync_q <= '1;
            cand_q     <= 4'hF;
            rcnt_q     <= '0;
            rot_q      <= 4'h0;
            chg_q      <= 1'b0;
        end else begin
            rot_sync_q <= {rot_sync_q[SyncStages-2:0], i_rotary};
            cand_q     <= cand_d;
            rcnt_q     <= rcnt_d;
            rot_q      <= rot_d;
            chg_q      <= chg_d;
        end
    end

    assign o_rotary  = rot_q;
    assign o_rot_chg = chg_q;

endmodule

// File: tb/tb_key_rotary_cond.sv
// Directed bench for key_rotary_cond with DB_CYCLES=20, REPEAT_DLY=100, REPEAT_PER=40.
// Inputs change 1 time unit after a rising edge; that edge is cycle 0 of the event and
// outputs are sampled 1 time unit after each following edge.
module tb_key_rotary_cond;

    logic       clk = 1'b0;
    logic       rstn = 1'b1;
    logic       key1 = 1'b1;
    logic       key2 = 1'b1;
    logic [3:0] rotary = 4'hF;
    logic       mode_pulse, clear_pulse, rot_chg;
    logic [1:0] key_held;
    logic [3:0] rot_val;

    // Packed view of every output: {mode, clear, held[1:0], rotary[3:0], chg}.
    logic [8:0] obs;
    assign obs = {mode_pulse, clear_pulse, key_held, rot_val, rot_chg};

    int total = 0;
    int bad   = 0;
    logic [3:0] rot_exp = 4'h0;

    key_rotary_cond #(
        .DB_CYCLES  (20),
        .REPEAT_DLY (100),
        .REPEAT_PER (40)
    ) dut (
        .i_clk         (clk),
        .i_rstn        (rstn),
        .i_key1_mode   (key1),
        .i_key2_clear  (key2),
        .i_rotary      (rotary),
        .o_mode_pulse  (mode_pulse),
        .o_clear_pulse (clear_pulse),
        .o_key_held    (key_held),
        .o_rotary      (rot_val),
        .o_rot_chg     (rot_chg)
    );

    always #50 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [8:0] exp;
        #20 rstn = 1'b0;
        tick();
        tick();
        for (int k = 0; k < 8; k++) begin
            tick();
            total++;
            if (obs !== 9'h000) begin
                bad++;
                $display("FAIL reset_hold k=%0d got=%h exp=%h", k, obs, 9'h000);
            end
        end
        rstn = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            tick();
            exp = {1'b0, 1'b0, 2'b00, rot_exp, 1'b0};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL reset_quiet k=%0d got=%h exp=%h", k, obs, exp);
            end
        end
    endtask

    task automatic test_press_mode();
        logic [8:0] exp;
        key1 = 1'b0;
        for (int k = 1; k <= 500; k++) begin
            tick();
            exp = {(k == 22), 1'b0, 1'b0, (k >= 22), rot_exp, 1'b0};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL mode_press k=%0d got=%h exp=%h", k, obs, exp);
            end
        end
        key1 = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            tick();
            exp = {1'b0, 1'b0, 1'b0, (k < 22), rot_exp, 1'b0};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL mode_release k=%0d got=%h exp=%h", k, obs, exp);
            end
        end
    endtask

    task automatic test_bounce_clear();
        logic [8:0] exp;
        exp = {1'b0, 1'b0, 2'b00, rot_exp, 1'b0};
        for (int k = 0; k < 140; k++) begin
            key2 = (k >= 100) ? 1'b1 : (((k / 5) % 2) == 1);
            tick();
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL clear_bounce k=%0d got=%h exp=%h", k, obs, exp);
            end
        end
    endtask

    task automatic test_both_keys();
        logic [8:0] exp;
        key1 = 1'b0;
        key2 = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            exp = {(k == 22), (k == 22), (k >= 22), (k >= 22), rot_exp, 1'b0};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL both_press k=%0d got=%h exp=%h", k, obs, exp);
            end
        end
        key1 = 1'b1;
        key2 = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            tick();
            exp = {1'b0, 1'b0, (k < 22), (k < 22), rot_exp, 1'b0};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL both_release k=%0d got=%h exp=%h", k, obs, exp);
            end
        end
    endtask

    task automatic test_held_reset();
        logic [8:0] exp;
        key1 = 1'b0;
        tick();
        tick();
        rstn = 1'b0;
        rot_exp = 4'h0;
        for (int k = 0; k < 10; k++) begin
            tick();
            total++;
            if (obs !== 9'h000) begin
                bad++;
                $display("FAIL held_in_reset k=%0d got=%h exp=%h", k, obs, 9'h000);
            end
        end
        rstn = 1'b1;
        exp = {1'b0, 1'b0, 2'b00, rot_exp, 1'b0};
        for (int k = 1; k <= 120; k++) begin
            if (k == 61) key1 = 1'b1;
            tick();
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL held_after_reset k=%0d got=%h exp=%h", k, obs, exp);
            end
        end
        key1 = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            exp = {(k == 22), 1'b0, 1'b0, (k >= 22), rot_exp, 1'b0};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL repress_after_reset k=%0d got=%h exp=%h", k, obs, exp);
            end
        end
        key1 = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            tick();
            exp = {1'b0, 1'b0, 1'b0, (k < 22), rot_exp, 1'b0};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL repress_release k=%0d got=%h exp=%h", k, obs, exp);
            end
        end
    endtask

    task automatic test_rotary();
        logic [8:0] exp;
        // Glitch to 4'hA (value 5) for 10 cycles, then settle on 4'hC (value 3).
        rotary = 4'hA;
        for (int k = 1; k <= 10; k++) begin
            tick();
            exp = {4'b0000, 4'h0, 1'b0};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL rot_glitch k=%0d got=%h exp=%h", k, obs, exp);
            end
        end
        rotary = 4'hC;
        for (int k = 1; k <= 40; k++) begin
            tick();
            exp = {4'b0000, (k >= 22) ? 4'h3 : 4'h0, (k == 22)};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL rot_settle3 k=%0d got=%h exp=%h", k, obs, exp);
            end
        end
        rot_exp = 4'h3;
        // Short excursion returning to the same code: value reloads unchanged, no strobe.
        rotary = 4'hE;
        for (int k = 1; k <= 45; k++) begin
            if (k == 6) rotary = 4'hC;
            tick();
            exp = {4'b0000, rot_exp, 1'b0};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL rot_same k=%0d got=%h exp=%h", k, obs, exp);
            end
        end
        rotary = 4'h6;
        for (int k = 1; k <= 40; k++) begin
            tick();
            exp = {4'b0000, (k >= 22) ? 4'h9 : 4'h3, (k == 22)};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL rot_settle9 k=%0d got=%h exp=%h", k, obs, exp);
            end
        end
        rot_exp = 4'h9;
    endtask

    task automatic test_long_hold();
        logic [8:0] exp;
        logic       exp_p;
        key1 = 1'b0;
        for (int k = 1; k <= 340; k++) begin
            tick();
`ifdef KEY_AUTOREPEAT_EN
            exp_p = (k == 22) || (k >= 122 && k <= 282 && ((k - 122) % 40) == 0);
`else
            exp_p = (k == 22);
`endif
            exp = {exp_p, 1'b0, 1'b0, (k >= 22 && k < 322), rot_exp, 1'b0};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL long_hold k=%0d got=%h exp=%h", k, obs, exp);
            end
            if (k == 300) key1 = 1'b1;
        end
    endtask

    initial begin
        test_reset();
        test_press_mode();
        test_bounce_clear();
        test_both_keys();
        test_held_reset();
        test_rotary();
        test_long_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
